ysyx_23060201_ctrl: RTL and testbench

YSYX_23060201_CTRL -- requirements
Module: ysyx_23060201_CTRL

---
 rtl/ysyx_23060201_ctrl_pkg.sv | 76 +++++++
 rtl/ysyx_23060201_ctrl_wdt.sv | 35 +++
 rtl/ysyx_23060201_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ysyx_23060201_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060201_ctrl_pkg.sv
// ysyx_23060201_ctrl_pkg: opcode constants, FSM state encoding and decode helpers
// shared by the core controller and its watchdog.
// Latency: n/a (types, constants and pure functions only). Backpressure: n/a.
package ysyx_23060201_ctrl_pkg;

    // RV32 major opcodes understood by the controller
    localparam logic [6:0] ysyx_23060201_OP_TYPE_R      = 7'b0110011;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_I      = 7'b0010011;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_IL     = 7'b0000011;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_S      = 7'b0100011;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_B      = 7'b1100011;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_U      = 7'b0110111;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_UPC    = 7'b0010111;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_J      = 7'b1101111;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_JR     = 7'b1100111;
    localparam logic [6:0] ysyx_23060201_OP_TYPE_SYSTEM = 7'b1110011;

    // func3 of the SYSTEM opcode that stops the core (ebreak/ecall group)
    localparam logic [2:0] ysyx_23060201_F3_TRAP = 3'b000;

    // Ten states need four bits internally. The debug port is only three bits
    // wide, so HALT/ERR alias onto IDLE/IF_REQ there; halt/err disambiguate.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_IF_REQ   = 4'd1,
        ST_IF_WAIT  = 4'd2,
        ST_ID       = 4'd3,
        ST_EX       = 4'd4,
        ST_MEM_REQ  = 4'd5,
        ST_MEM_WAIT = 4'd6,
        ST_WB       = 4'd7,
        ST_HALT     = 4'd8,
        ST_ERR      = 4'd9
    } ctrl_state_e;

    function automatic logic op_is_legal(input logic [6:0] op);
        logic ok;
        case (op)
            ysyx_23060201_OP_TYPE_R,
            ysyx_23060201_OP_TYPE_I,
            ysyx_23060201_OP_TYPE_IL,
            ysyx_23060201_OP_TYPE_S,
            ysyx_23060201_OP_TYPE_B,
            ysyx_23060201_OP_TYPE_U,
            ysyx_23060201_OP_TYPE_UPC,
            ysyx_23060201_OP_TYPE_J,
            ysyx_23060201_OP_TYPE_JR,
            ysyx_23060201_OP_TYPE_SYSTEM: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Loads and stores are the only instructions that visit the LSU
    function automatic logic op_is_mem(input logic [6:0] op);
        return (op == ysyx_23060201_OP_TYPE_IL) || (op == ysyx_23060201_OP_TYPE_S);
    endfunction

    // Stores and branches have no destination register
    function automatic logic op_writes_gpr(input logic [6:0] op);
        return !((op == ysyx_23060201_OP_TYPE_S) || (op == ysyx_23060201_OP_TYPE_B));
    endfunction

    // States in which the core waits on a bus and the watchdog runs
    function automatic logic st_is_bus(input ctrl_state_e st);
        return (st == ST_IF_REQ) || (st == ST_IF_WAIT) ||
               (st == ST_MEM_REQ) || (st == ST_MEM_WAIT);
    endfunction

    function automatic logic [2:0] st_debug(input ctrl_state_e st);
        logic [3:0] v;
        v = st;
        return v[2:0];
    endfunction

endpackage

// File: rtl/ysyx_23060201_ctrl_wdt.sv
// ysyx_23060201_ctrl_wdt: bus watchdog counting cycles spent waiting in one bus state.
// Latency: o_timeout is combinational from the count register (same cycle it reaches all-ones).
// Backpressure: none; the FSM reacts to o_timeout by abandoning the transaction.
//
// Ports: clk/rst       clock and synchronous active-high reset
//        i_clear       zero the count (asserted on the cycle a bus state is entered)
//        i_enable      count this cycle (asserted while in a bus state)
//        o_timeout     count has reached 2^TIMEOUT_W-1 while enabled
module ysyx_23060201_ctrl_wdt #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    logic [TIMEOUT_W-1:0] r_cnt;

    // Clear wins over enable: leaving one bus state for another restarts the budget
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count never wraps: the FSM leaves the bus state as soon as this fires
    assign o_timeout = i_enable && (r_cnt == {TIMEOUT_W{1'b1}});

endmodule

// File: rtl/ysyx_23060201_ctrl.sv
// ysyx_23060201_ctrl: multi-cycle core sequencer (fetch/decode/execute/mem/writeback).
// Latency: 5 cycles per non-memory instruction on a zero-wait bus; outputs are registered state decodes.
// Backpressure: holds *_req_valid until ready, waits for *_rsp_valid; watchdog aborts to ERR.
//
// Ports: clk, rst (sync, active-high); ifu_req_valid/ready, ifu_rsp_valid: fetch bus;
//        inst_op, inst_func3: decoded instruction fields; lsu_req_valid/ready, lsu_rsp_valid:
//        load/store bus; inst_latch_en, gpr_wen, pc_wen: datapath strobes; halt, err: sticky
//        status; state: 3-bit debug view of the FSM.
// Optional: define YSYX_23060201_PERF_CNT_EN to add 64-bit cyc_cnt and inst_cnt outputs.
module ysyx_23060201_ctrl
    import ysyx_23060201_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic       ifu_req_valid,
    input  logic       ifu_req_ready,
    input  logic       ifu_rsp_valid,
    input  logic [6:0] inst_op,
    input  logic [2:0] inst_func3,
    output logic       lsu_req_valid,
    input  logic       lsu_req_ready,
    input  logic       lsu_rsp_valid,
    output logic       inst_latch_en,
    output logic       gpr_wen,
    output logic       pc_wen,
    output logic       halt,
    output logic       err,
    output logic [2:0] state
`ifdef YSYX_23060201_PERF_CNT_EN
    ,
    output logic [63:0] cyc_cnt,
    output logic [63:0] inst_cnt
`endif
);

    ctrl_state_e r_state;
    ctrl_state_e w_next;
    logic [6:0]  r_op;
    logic        w_timeout;
    logic        w_wdt_clear;
    logic        w_wdt_enable;

    // Watchdog restarts on every entry into a bus state, including
    // REQ->WAIT, so request and response phases each get a full budget.
    assign w_wdt_enable = st_is_bus(r_state);
    assign w_wdt_clear  = st_is_bus(w_next) && (w_next != r_state);

    ysyx_23060201_ctrl_wdt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wdt_clear),
        .i_enable  (w_wdt_enable),
        .o_timeout (w_timeout)
    );

    // Next-state logic. Inputs only steer transitions; the registered outputs
    // below are decoded from the chosen next state, so no input reaches a port
    // combinationally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = ST_IF_REQ;

            // Timeout is checked first so it beats a same-cycle handshake.
            // Responses are not looked at here: one arriving with acceptance is dropped.
            ST_IF_REQ: begin
                if (w_timeout)          w_next = ST_ERR;
                else if (ifu_req_ready) w_next = ST_IF_WAIT;
            end

            ST_IF_WAIT: begin
                if (w_timeout)          w_next = ST_ERR;
                else if (ifu_rsp_valid) w_next = ST_ID;
            end

            ST_ID: begin
                if ((inst_op == ysyx_23060201_OP_TYPE_SYSTEM) &&
                    (inst_func3 == ysyx_23060201_F3_TRAP))
                    w_next = ST_HALT;
                else if (!op_is_legal(inst_op))
                    w_next = ST_ERR;
                else
                    w_next = ST_EX;
            end

            ST_EX: w_next = op_is_mem(r_op) ? ST_MEM_REQ : ST_WB;

            ST_MEM_REQ: begin
                if (w_timeout)          w_next = ST_ERR;
                else if (lsu_req_ready) w_next = ST_MEM_WAIT;
            end

            ST_MEM_WAIT: begin
                if (w_timeout)          w_next = ST_ERR;
                else if (lsu_rsp_valid) w_next = ST_WB;
            end

            ST_WB:   w_next = ST_IF_REQ;
            ST_HALT: w_next = ST_HALT;
            ST_ERR:  w_next = ST_ERR;
            default: w_next = ST_ERR;
        endcase
    end

    // State register plus registered Moore outputs. Each output flop holds the
    // decode of the state being entered, so it is always equal to a decode of
    // r_state. Reset drops any outstanding request without a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            ifu_req_valid <= 1'b0;
            lsu_req_valid <= 1'b0;
            inst_latch_en <= 1'b0;
            gpr_wen       <= 1'b0;
            pc_wen        <= 1'b0;
            halt          <= 1'b0;
            err           <= 1'b0;
            state         <= 3'd0;
        end else begin
            r_state       <= w_next;
            ifu_req_valid <= (w_next == ST_IF_REQ);
            lsu_req_valid <= (w_next == ST_MEM_REQ);
            inst_latch_en <= (w_next == ST_ID);
            pc_wen        <= (w_next == ST_WB);
            // WB is only ever entered from EX or MEM_WAIT, by which time r_op
            // already holds this instruction's opcode.
            gpr_wen       <= (w_next == ST_WB) && op_writes_gpr(r_op);
            halt          <= (w_next == ST_HALT);
            err           <= (w_next == ST_ERR);
            state         <= st_debug(w_next);
            // Keep the opcode seen in ID for the EX and WB decisions
            if (r_state == ST_ID) begin
                r_op <= inst_op;
            end
        end
    end

`ifdef YSYX_23060201_PERF_CNT_EN
    logic [63:0] r_cyc_cnt;
    logic [63:0] r_inst_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 64'd1;
            // One retired instruction per writeback cycle
            if (r_state == ST_WB) begin
                r_inst_cnt <= r_inst_cnt + 64'd1;
            end
        end
    end

    assign cyc_cnt  = r_cyc_cnt;
    assign inst_cnt = r_inst_cnt;
`endif

endmodule

// File: tb/tb_ysyx_23060201_ctrl.sv
// tb_ysyx_23060201_ctrl: schedules each instruction as a timeline of phases
// (request/wait lengths, decode, execute, writeback) and checks every cycle.
// Latency: n/a. Backpressure: the bench plays both bus slaves with random delays.
module tb_ysyx_23060201_ctrl;

    localparam int TW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
    logic [6:0] inst_op = '0;
    logic [2:0] inst_func3 = '0;
    logic       lsu_req_valid, lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
    logic       inst_latch_en, gpr_wen, pc_wen, halt, err;
    logic [2:0] state;
`ifdef YSYX_23060201_PERF_CNT_EN
    logic [63:0] cyc_cnt, inst_cnt;
    logic [63:0] m_cyc = '0, m_inst = '0;
`endif

    always #5 clk = ~clk;

    ysyx_23060201_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .inst_op       (inst_op),
        .inst_func3    (inst_func3),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .inst_latch_en (inst_latch_en),
        .gpr_wen       (gpr_wen),
        .pc_wen        (pc_wen),
        .halt          (halt),
        .err           (err),
        .state         (state)
`ifdef YSYX_23060201_PERF_CNT_EN
        ,
        .cyc_cnt       (cyc_cnt),
        .inst_cnt      (inst_cnt)
`endif
    );

    // Expected-output bit order: {ifu_req_valid, lsu_req_valid, inst_latch_en, gpr_wen, pc_wen, halt, err}
    localparam logic [6:0] E_IFU  = 7'b1000000;
    localparam logic [6:0] E_LSU  = 7'b0100000;
    localparam logic [6:0] E_LAT  = 7'b0010000;
    localparam logic [6:0] E_GPR  = 7'b0001000;
    localparam logic [6:0] E_PC   = 7'b0000100;
    localparam logic [6:0] E_HALT = 7'b0000010;
    localparam logic [6:0] E_ERR  = 7'b0000001;

    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_IL  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};

    typedef struct {
        logic       rst;
        logic       ifr, ifs, lr, ls;
        logic [6:0] op;
        logic [2:0] f3;
        logic       chk;
        logic       idle;
        logic [6:0] ex;
    } ent_t;

    ent_t q[$];
    logic [6:0] cur_op = '0;
    logic [2:0] cur_f3 = '0;

    int checks = 0;
    int errors = 0;

    // Observations of the DUT, gathered by the compare process per section
    int since_idle, first_latch, first_pc, first_gpr;
    int cnt_ifu, cnt_lsu, cnt_gpr, cnt_pc, cnt_halt, cnt_err;

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic r, ifr, ifs, lr, ls, chk, idle, input logic [6:0] ex);
        ent_t e;
        e.rst = r; e.ifr = ifr; e.ifs = ifs; e.lr = lr; e.ls = ls;
        e.op = cur_op; e.f3 = cur_f3; e.chk = chk; e.idle = idle; e.ex = ex;
        q.push_back(e);
    endtask

    // n reset cycles followed by the single IDLE cycle
    task automatic gen_reset(input int n, input logic chk_first);
        cur_op = 7'($urandom); cur_f3 = 3'($urandom);
        for (int i = 0; i < n; i++) push(1'b1, rb(), rb(), rb(), rb(), (i > 0) || chk_first, 1'b0, 7'd0);
        push(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b1, 7'd0);
    endtask

    task automatic push_tail(input logic [6:0] ex, input int n);
        for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, ex);
    endtask

    // Request phase: ready first offered after dreq idle cycles. The watchdog
    // allows handshakes on cycles 0..2^TW-2 of a state; on cycle 2^TW-1 the
    // core gives up even if the slave answers then.
    task automatic gen_bus(input logic lsu, input int dreq, input int drsp, output logic ok);
        int lim, last;
        logic rdy, rsp;
        lim = (1 << TW) - 1;
        ok = 1'b1;
        last = (dreq >= lim) ? lim : dreq;
        for (int j = 0; j <= last; j++) begin
            rdy = (j == last);
            rsp = rb();
            if (lsu) push(1'b0, rb(), rb(), rdy, rsp, 1'b1, 1'b0, E_LSU);
            else     push(1'b0, rdy, rsp, rb(), rb(), 1'b1, 1'b0, E_IFU);
        end
        if (dreq >= lim) begin
            ok = 1'b0;
        end else begin
            last = (drsp >= lim) ? lim : drsp;
            for (int j = 0; j <= last; j++) begin
                rsp = (j == last);
                if (lsu) push(1'b0, rb(), rb(), rb(), rsp, 1'b1, 1'b0, 7'd0);
                else     push(1'b0, rb(), rsp, rb(), rb(), 1'b1, 1'b0, 7'd0);
            end
            if (drsp >= lim) ok = 1'b0;
        end
    endtask

    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int d0, d1, d2, d3, input int ntail, output logic dead);
        logic ok;
        cur_op = op; cur_f3 = f3; dead = 1'b0;
        gen_bus(1'b0, d0, d1, ok);
        if (!ok) begin
            push_tail(E_ERR, ntail); dead = 1'b1;
        end else begin
            push(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, E_LAT);
            if (op == OP_SYS && f3 == 3'b000) begin
                push_tail(E_HALT, ntail); dead = 1'b1;
            end else if (!is_legal(op)) begin
                push_tail(E_ERR, ntail); dead = 1'b1;
            end else begin
                push(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, 7'd0);
                ok = 1'b1;
                if (op == OP_IL || op == OP_S) gen_bus(1'b1, d2, d3, ok);
                if (!ok) begin
                    push_tail(E_ERR, ntail); dead = 1'b1;
                end else begin
                    push(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0,
                         E_PC | ((op != OP_S && op != OP_B) ? E_GPR : 7'd0));
                end
            end
        end
    endtask

    task automatic clr_mon();
        since_idle = 0; first_latch = -1; first_pc = -1; first_gpr = -1;
        cnt_ifu = 0; cnt_lsu = 0; cnt_gpr = 0; cnt_pc = 0; cnt_halt = 0; cnt_err = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20000 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d required=0", q.size());
            q.delete();
        end
        @(posedge clk); #2;
    endtask

    task automatic lit(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", nm, got, want);
        end
    endtask

    // Driver and compare process: one table entry per clock cycle
    initial begin : cmp
        ent_t e;
        logic [6:0] act;
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (q.size() == 0) begin
                rst = 1'b1;
            end else begin
                e = q.pop_front();
                rst = e.rst; ifu_req_ready = e.ifr; ifu_rsp_valid = e.ifs;
                lsu_req_ready = e.lr; lsu_rsp_valid = e.ls;
                inst_op = e.op; inst_func3 = e.f3;
                act = {ifu_req_valid, lsu_req_valid, inst_latch_en, gpr_wen, pc_wen, halt, err};
                if (e.chk) begin
                    checks++;
                    if (act !== e.ex) begin
                        errors++;
                        $display("FAIL outputs cyc=%0d got ifu/lsu/latch/gpr/pc/halt/err=%b required=%b",
                                 cyc, act, e.ex);
                    end
`ifdef YSYX_23060201_PERF_CNT_EN
                    checks++;
                    if (cyc_cnt !== m_cyc || inst_cnt !== m_inst) begin
                        errors++;
                        $display("FAIL perf cyc=%0d got cyc_cnt=%0d inst_cnt=%0d required %0d %0d",
                                 cyc, cyc_cnt, inst_cnt, m_cyc, m_inst);
                    end
`endif
                end
                if (e.idle) begin
                    since_idle = 0; first_latch = -1; first_pc = -1; first_gpr = -1;
                    checks++;
                    if (state !== 3'd0) begin
                        errors++;
                        $display("FAIL idle_state cyc=%0d got=%0d required=0", cyc, state);
                    end
                end
                if (inst_latch_en && first_latch < 0) first_latch = since_idle;
                if (pc_wen && first_pc < 0)           first_pc = since_idle;
                if (gpr_wen && first_gpr < 0)         first_gpr = since_idle;
                cnt_ifu  += int'(ifu_req_valid);
                cnt_lsu  += int'(lsu_req_valid);
                cnt_gpr  += int'(gpr_wen);
                cnt_pc   += int'(pc_wen);
                cnt_halt += int'(halt);
                cnt_err  += int'(err);
                since_idle++;
`ifdef YSYX_23060201_PERF_CNT_EN
                m_cyc  = e.rst ? 64'd0 : m_cyc + 64'd1;
                m_inst = e.rst ? 64'd0 : m_inst + ((e.ex & E_PC) != 0 ? 64'd1 : 64'd0);
`endif
            end
        end
    end

    initial begin : main
        logic dead;
        int k, d[4];
        logic [6:0] op;
        logic [2:0] f3;
        clr_mon();
        repeat (2) @(posedge clk);

        // ADDI on zero-wait buses: latch at cycle 3, writeback at cycle 5
        clr_mon(); gen_reset(3, 1'b0);
        gen_instr(OP_I, 3'd0, 0, 0, 0, 0, 0, dead);
        drain();
        lit("addi_latch_cycle", first_latch, 3);
        lit("addi_pc_cycle", first_pc, 5);
        lit("addi_gpr_cycle", first_gpr, 5);

        // LW: ready after 3 cycles, response 2 cycles later
        clr_mon(); gen_reset(2, 1'b0);
        gen_instr(OP_IL, 3'd2, 0, 0, 3, 2, 0, dead);
        drain();
        lit("lw_lsu_valid_cycles", cnt_lsu, 4);
        lit("lw_gpr_wen_count", cnt_gpr, 1);

        // SW then BEQ: PC written twice, no register write
        clr_mon(); gen_reset(2, 1'b0);
        gen_instr(OP_S, 3'd2, 1, 0, 0, 1, 0, dead);
        gen_instr(OP_B, 3'd0, 0, 2, 0, 0, 0, dead);
        drain();
        lit("sw_beq_pc_wen", cnt_pc, 2);
        lit("sw_beq_gpr_wen", cnt_gpr, 0);

        // ebreak: halt sticky, no further fetch
        clr_mon(); gen_reset(2, 1'b0);
        gen_instr(OP_SYS, 3'd0, 0, 0, 0, 0, 20, dead);
        drain();
        lit("ebreak_halt_cycles", cnt_halt, 20);
        lit("ebreak_ifu_valid_cycles", cnt_ifu, 1);

        // Fetch ready withheld: 2^TW cycles in IF_REQ, then ERR
        clr_mon(); gen_reset(2, 1'b0);
        gen_instr(OP_I, 3'd0, 99, 0, 0, 0, 10, dead);
        drain();
        lit("timeout_ifu_valid_cycles", cnt_ifu, 16);
        lit("timeout_err_cycles", cnt_err, 10);

        // Last-legal handshake cycle in both request and wait phases
        clr_mon(); gen_reset(2, 1'b0);
        gen_instr(OP_IL, 3'd0, 14, 14, 14, 14, 0, dead);
        drain();
        lit("edge_wdt_err_cycles", cnt_err, 0);
        lit("edge_wdt_gpr_wen", cnt_gpr, 1);

        // Illegal opcode straight to ERR
        clr_mon(); gen_reset(2, 1'b0);
        gen_instr(7'b0000000, 3'd0, 0, 0, 0, 0, 6, dead);
        drain();
        lit("illegal_err_cycles", cnt_err, 6);
        lit("illegal_pc_wen", cnt_pc, 0);

        // Reset pulse during MEM_WAIT, then a normal ADDI
        clr_mon(); gen_reset(2, 1'b0);
        cur_op = OP_IL; cur_f3 = 3'd2;
        gen_bus(1'b0, 0, 0, dead);
        push(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, E_LAT);
        push(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, 7'd0);
        push(1'b0, rb(), rb(), 1'b0, rb(), 1'b1, 1'b0, E_LSU);
        push(1'b0, rb(), rb(), 1'b1, rb(), 1'b1, 1'b0, E_LSU);
        push(1'b0, rb(), rb(), rb(), 1'b0, 1'b1, 1'b0, 7'd0);
        push(1'b0, rb(), rb(), rb(), 1'b0, 1'b1, 1'b0, 7'd0);
        gen_reset(1, 1'b1);
        gen_instr(OP_I, 3'd0, 0, 0, 0, 0, 0, dead);
        drain();
        lit("mid_reset_latch_cycle", first_latch, 3);
        lit("mid_reset_pc_wen", cnt_pc, 1);

        // Random instruction stream
        clr_mon(); gen_reset(2, 1'b0);
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 15);
            f3 = 3'($urandom);
            if (k < 10)       op = legal_ops[k];
            else if (k == 10) begin op = OP_SYS; f3 = 3'd0; end
            else if (k == 11) op = 7'($urandom);
            else              op = legal_ops[$urandom_range(0, 9)];
            for (int j = 0; j < 4; j++)
                d[j] = ($urandom_range(0, 24) == 0) ? 20 : $urandom_range(0, 4);
            gen_instr(op, f3, d[0], d[1], d[2], d[3], $urandom_range(1, 4), dead);
            if (dead) gen_reset($urandom_range(1, 3), 1'b0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
